// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, line levels and widths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = 16;
  localparam int unsigned UART_IDX_W     = 3;
  localparam int unsigned UART_LEVEL_W   = 16;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/axis_uart_tx_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
interface axis_uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] i_tdata;
  logic                      i_tvalid;
  logic                      i_tready;

  modport master (output i_tdata, output i_tvalid, input  i_tready);
  modport slave  (input  i_tdata, input  i_tvalid, output i_tready);

endinterface

// File: rtl/simple_uart_tx.sv
// 8N1 serializer: pops a byte when available and shifts it out LSB-first,
// chaining frames without an idle gap while data keeps coming.
module simple_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKDIV = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data_i,
  input  logic                      valid_i,
  output logic                      pop_c_o,
  output logic                      active_c_o,
  output logic                      tx_o
);

  localparam logic [UART_CNT_W-1:0] RELOAD   = UART_CNT_W'(CLKDIV - 1);
  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_CNT_W-1:0]     cnt_q, cnt_d;
  logic [UART_IDX_W-1:0]     idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_c_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          pop_c_o = 1'b1;
          shift_d = data_i;
          cnt_d   = RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - UART_CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + UART_IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - UART_CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Last stop cycle: chain straight into the next start bit if data waits.
        if (cnt_q == '0) begin
          if (valid_i) begin
            pop_c_o = 1'b1;
            shift_d = data_i;
            cnt_d   = RELOAD;
            state_d = ST_START;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - UART_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level is registered from the state being entered.
    unique case (state_d)
      ST_START: tx_d = UART_START_BIT;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = UART_STOP_BIT;
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign tx_o       = tx_q;
  assign active_c_o = (state_q != ST_IDLE);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter: byte FIFO in front of an 8N1 serializer.
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned TX_SIZE = 4,
  parameter int unsigned CLKDIV  = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_uart_tx_if.slave           s_axis,
  output logic                    tx,
  output logic [UART_LEVEL_W-1:0] fifo_level,
  output logic                    busy
);

  localparam int unsigned PTR_W = TX_SIZE;
  localparam int unsigned CNT_W = TX_SIZE + 1;
  localparam int unsigned DEPTH = 1 << TX_SIZE;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      tready_q;
  logic                      push, pop, empty, active;

  assign push  = s_axis.i_tvalid & tready_q;
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      tready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis.i_tdata;
  end

  simple_uart_tx #(
    .CLKDIV (CLKDIV)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .data_i     (mem_q[rd_ptr_q]),
    .valid_i    (!empty),
    .pop_c_o    (pop),
    .active_c_o (active),
    .tx_o       (tx)
  );

  assign s_axis.i_tready = tready_q;
  assign fifo_level      = UART_LEVEL_W'(count_q);
  assign busy            = active | !empty;

endmodule

// File: doc/axis_uart_tx.md
# axis_uart_tx

AXI-Stream-to-UART transmitter: accepts bytes on an AXI-Stream slave port, buffers them in an internal FIFO, and serializes them onto a single `tx` line as 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity). It is the transmit-side counterpart of the stream UART receiver, and a host-facing debug/console link uses the two blocks as a pair. The bit period is fixed at elaboration time in clock cycles.

## Interface
- `TX_SIZE`, 4: log2 of FIFO depth (depth = 2^TX_SIZE entries); legal 1..15.
- `CLKDIV`, 100: clock cycles per UART bit; legal 2..65535.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_tdata`  input  8  byte to transmit.
- `i_tvalid`  input  1  `i_tdata` valid.
- `i_tready`  output  1  FIFO can accept; equals FIFO not full.
- `tx`  output  1  serial line, idle high; registered.
- `fifo_level`  output  16  number of bytes held in FIFO (excludes byte in serializer); zero-extended.
- `busy`  output  1  high while a frame is being shifted out or FIFO non-empty.

## Operation
- Push: `i_tvalid & i_tready` on a rising edge writes `i_tdata` to FIFO tail.
- `i_tready` = !full; depends only on registered FIFO state, never on `i_tvalid`.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop head into 8-bit shift register, load baud counter with CLKDIV-1, go START.
  - START: `tx`=0 for CLKDIV cycles, then go DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKDIV cycles per bit; shift right after each bit; after bit index 7, go STOP.
  - STOP: `tx`=1 for CLKDIV cycles. At last cycle: if FIFO non-empty, pop and go START directly (no idle gap); else go IDLE.
- Baud counter: 16-bit down-counter, reloads CLKDIV-1 at each bit boundary; bit index: 3-bit counter.
- Simultaneous push and pop: both take effect; `fifo_level` unchanged.
- Push when full: impossible (`i_tready`=0); data on bus ignored.
- FIFO pointers: TX_SIZE-bit, wrap modulo 2^TX_SIZE; full/empty from a TX_SIZE+1-bit count.
- `busy` = (state != IDLE) | !empty.

## Timing
- Reset values: `tx`=1, `i_tready`=1, `fifo_level`=0, `busy`=0, FSM=IDLE, counters 0, FIFO empty. Reset mid-frame aborts the frame immediately; `tx` returns high asynchronously; buffered bytes discarded.
- Latency: byte accepted on edge N into empty FIFO with FSM idle -> popped on edge N+1; `tx` low from edge N+1 (registered with pop).
- Frame length exactly 10*CLKDIV cycles; each bit exactly CLKDIV cycles.
- Back-to-back: next start bit begins the cycle after the previous stop bit's last cycle.
- `fifo_level` and `i_tready` update one cycle after the push/pop edge (registered).
- Effective capacity before `i_tready` drops with serializer busy: 2^TX_SIZE bytes in FIFO plus 1 in shift register.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE/START/DATA/STOP), `UART_DATA_BITS`=8, `UART_START_BIT`=0, `UART_STOP_BIT`=1, `UART_IDLE_LEVEL`=1.
- One sub-module: `simple_uart_tx` (serializer FSM + baud counter + shift register, input byte/valid, output `tx`/pop strobe). FIFO storage and pointer logic inline in `axis_uart_tx`.

## Test plan
- CLKDIV=4, single byte 0xA5 -> `tx` levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, start bit begins edge N+1; `busy` falls after 40 cycles.
- CLKDIV=4, bytes 0x00 then 0xFF pushed back-to-back -> 80 contiguous cycles, second start bit directly after first stop bit, no idle cycle.
- TX_SIZE=4, `i_tvalid` held high with 20 bytes -> exactly 17 accepted before `i_tready`=0, `fifo_level`=16; `i_tready` returns 1 one cycle after next pop; all 20 bytes emitted in order.
- Assert `rst` at cycle 15 of a 0x3C frame (CLKDIV=4) with 3 bytes queued -> `tx`=1 immediately, `fifo_level`=0, `i_tready`=1, no further frames after release.
- Push and pop in same cycle with `fifo_level`=5 -> `fifo_level` stays 5.
- `i_tvalid` held 0 for 1000 cycles after reset -> `tx`=1, `busy`=0 throughout.
